enc_dec_seq: RTL and testbench
==============================

# enc_dec_seq

Command sequencer between the APB register file and the encoder/decoder core. On a start strobe it latches the programmed operation, data, codeword width and noise word, then drives the core through encode, decode, or full-channel (encode, inject noise, decode). It returns the result word and error count to the register/status side. One command is in flight at a time.

## Interface
- DATA_WIDTH, 32, width of data, noise and result words
- TIMEOUT, 255, max WAIT cycles per core transaction (watchdog build only)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, issued when CTRL is written
- ctrl_op  in  2  00 encode, 01 decode, 10 full channel, 11 illegal
- data_in  in  DATA_WIDTH  input word
- codeword_width  in  2  00 8-bit, 01 16-bit, 10/11 32-bit
- noise  in  DATA_WIDTH  XOR error pattern (full channel only)
- core_start  out  1  one-cycle request to core
- core_mode  out  1  0 encode, 1 decode
- core_width  out  2  latched codeword_width
- core_din  out  DATA_WIDTH  operand to core
- core_done  in  1  core result valid, one-cycle pulse
- core_dout  in  DATA_WIDTH  core result
- core_nerr  in  2  errors detected by decoder
- data_out  out  DATA_WIDTH  final result, held until next DONE
- num_of_errors  out  2  decoder error count; 00 for encode; 11 on illegal/timeout
- operation_done  out  1  one-cycle completion pulse
- busy  out  1  high while a command is in flight
- timeout_err  out  1  set with operation_done when watchdog fired; cleared on next start

## Operation
- States: IDLE, ISSUE, WAIT, NOISE, DONE.
- IDLE + start: latch ctrl_op, data_in, codeword_width, noise -> ISSUE; op 11 -> DONE directly with data_out=0, num_of_errors=11.
- ISSUE: core_start=1 for one cycle. core_mode=0 for encode and the first pass of full channel, 1 for decode. -> WAIT.
- WAIT: core_done only honoured here. Encode/decode -> DONE. Full-channel first pass -> NOISE.
- NOISE: core_din <= core_dout ^ (noise & width_mask). Then -> ISSUE with mode=decode.
- width_mask: 8'hFF, 16'hFFFF or all-ones for 00/01/1x. Zero-extended to DATA_WIDTH. core_dout bits above width are passed through unmasked.
- DONE: data_out and num_of_errors registered, operation_done=1 -> IDLE.
- start while busy: ignored, no latching. core_done outside WAIT: ignored.
- Reset values: all outputs 0, state IDLE. Reset mid-operation aborts immediately with no operation_done.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: ISSUE, core_start=1, busy=1.
- Cycle 2 onward: WAIT. If core_done is sampled at cycle k, cycle k+1 is DONE with operation_done=1, and cycle k+2 is IDLE with busy=0.
- Encode/decode latency: k+1 cycles from start. Full channel adds one NOISE cycle plus a second ISSUE/WAIT.
- A start in the same cycle as DONE is ignored. The earliest accepted start is in the IDLE cycle after DONE.
- busy is high from ISSUE through DONE inclusive. busy is never high in IDLE.

## Configuration
- ENC_DEC_SEQ_TIMEOUT_EN defined:
  - A watchdog counts WAIT cycles and clears on entry to WAIT.
  - When the count reaches TIMEOUT without core_done: go to DONE with timeout_err=1, data_out=0, num_of_errors=11.
  - A core_done in the same cycle as the limit wins, and the result is normal.
- Not defined: no counter. WAIT is unbounded and timeout_err is tied 0. The port exists in both builds.

## Structure
- enc_dec_pkg holds:
  - op enum (ENC, DEC, CHAN, ILLEGAL), width enum, FSM state enum
  - width_mask function, NERR_INVALID = 2'b11
- One sub-module, enc_dec_seq_wdog: loadable down-counter with an expire flag. It is instantiated only under ENC_DEC_SEQ_TIMEOUT_EN.

## Test plan
- **Encode:** op=00, data_in=32'h0000_00A5, width=00, core returns 32'h0000_0A5B two cycles after core_start. Expect one core_start with mode=0, data_out=32'h0000_0A5B, num_of_errors=00, operation_done at cycle 4.
- **Full channel:** op=10, width=00, noise=32'h0000_0101, first core_dout=32'h0000_00F0. Expect second core_din=32'h0000_00F1 (mask 8'hFF), mode=1, and data_out/num_of_errors equal to the decode response (e.g. 01).
- **Illegal op:** op=11. Expect no core_start, operation_done at cycle 1, data_out=0, num_of_errors=11.
- **Busy/ignored events:**
  - A start pulse during WAIT and a stray core_done during IDLE: no latching, no extra operation_done.
  - start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- **Reset mid-command:** rst asserted in WAIT. All outputs 0 asynchronously, no operation_done. A new encode after deassertion completes normally.
- **Watchdog (macro on, TIMEOUT=4):** core never responds. Expect timeout_err=1 with operation_done, data_out=0, num_of_errors=11. A core_done on the limit cycle gives a normal result instead.

Source files
------------

// File: rtl/enc_dec_pkg.sv
// Shared types and helpers for the encoder/decoder command sequencer.
package enc_dec_pkg;

  typedef enum logic [1:0] {
    ENC     = 2'b00,
    DEC     = 2'b01,
    CHAN    = 2'b10,
    ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    W8   = 2'b00,
    W16  = 2'b01,
    W32  = 2'b10,
    W32X = 2'b11
  } width_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StNoise,
    StDone
  } state_e;

  localparam logic [1:0] NERR_INVALID = 2'b11;

  // Noise mask covering only the active codeword bits.
  function automatic logic [31:0] width_mask(width_e w);
    logic [31:0] m;
    case (w)
      W8:      m = 32'h0000_00FF;
      W16:     m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/enc_dec_seq_wdog.sv
// Loadable down-counter bounding one core transaction; expire is high once the count hits zero.
module enc_dec_seq_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Loaded one short so the TIMEOUT-th WAIT cycle sees zero.
  localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/enc_dec_seq.sv
// Command sequencer driving the encoder/decoder core through encode, decode or full channel.
// Optional watchdog on core transactions: define ENC_DEC_SEQ_TIMEOUT_EN.
module enc_dec_seq
  import enc_dec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            ctrl_op,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            codeword_width,
  input  logic [DATA_WIDTH-1:0] noise,
  output logic                  core_start,
  output logic                  core_mode,
  output logic [1:0]            core_width,
  output logic [DATA_WIDTH-1:0] core_din,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_dout,
  input  logic [1:0]            core_nerr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors,
  output logic                  operation_done,
  output logic                  busy,
  output logic                  timeout_err
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  width_e                width_q, width_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [1:0]            nerr_q, nerr_d;
  logic                  pass2_q, pass2_d;
  logic                  wdog_expire;
  logic                  to_set, to_clr;
  logic [DATA_WIDTH-1:0] mask;

  always_comb begin
    if (width_q == W32 || width_q == W32X) begin
      mask = '1;
    end else begin
      mask = DATA_WIDTH'(width_mask(width_q));
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    width_d = width_q;
    din_d   = din_q;
    noise_d = noise_q;
    dout_d  = dout_q;
    nerr_d  = nerr_q;
    pass2_d = pass2_q;
    to_set  = 1'b0;
    to_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_e'(ctrl_op);
          width_d = width_e'(codeword_width);
          din_d   = data_in;
          noise_d = noise;
          pass2_d = 1'b0;
          to_clr  = 1'b1;
          if (op_e'(ctrl_op) == ILLEGAL) begin
            dout_d  = '0;
            nerr_d  = NERR_INVALID;
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (core_done) begin
          if (op_q == CHAN && !pass2_q) begin
            din_d   = core_dout;
            state_d = StNoise;
          end else begin
            dout_d  = core_dout;
            nerr_d  = (op_q == ENC) ? 2'b00 : core_nerr;
            state_d = StDone;
          end
        end else if (wdog_expire) begin
          dout_d  = '0;
          nerr_d  = NERR_INVALID;
          to_set  = 1'b1;
          state_d = StDone;
        end
      end
      StNoise: begin
        // Bits above the codeword width pass through untouched.
        din_d   = din_q ^ (noise_q & mask);
        pass2_d = 1'b1;
        state_d = StIssue;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= ENC;
      width_q <= W8;
      din_q   <= '0;
      noise_q <= '0;
      dout_q  <= '0;
      nerr_q  <= '0;
      pass2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      width_q <= width_d;
      din_q   <= din_d;
      noise_q <= noise_d;
      dout_q  <= dout_d;
      nerr_q  <= nerr_d;
      pass2_q <= pass2_d;
    end
  end

  assign core_start     = (state_q == StIssue);
  assign core_mode      = (op_q == DEC) || pass2_q;
  assign core_width     = width_q;
  assign core_din       = din_q;
  assign data_out       = dout_q;
  assign num_of_errors  = nerr_q;
  assign operation_done = (state_q == StDone);
  assign busy           = (state_q != StIdle);

`ifdef ENC_DEC_SEQ_TIMEOUT_EN
  logic timeout_q;

  enc_dec_seq_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .load  (state_q == StIssue),
    .dec   (state_q == StWait),
    .expire(wdog_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (to_clr) begin
      timeout_q <= 1'b0;
    end else if (to_set) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_cfg;
  assign wdog_expire = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = ^{TIMEOUT, to_set, to_clr};
`endif

endmodule

// File: tb/tb_enc_dec_seq.sv
// Directed bench for enc_dec_seq with a transaction-level reference scoreboard.
`timescale 1ns/1ps
module tb_enc_dec_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    ctrl_op = '0;
  logic [DW-1:0] data_in = '0;
  logic [1:0]    codeword_width = '0;
  logic [DW-1:0] noise = '0;
  logic          core_start, core_mode;
  logic [1:0]    core_width;
  logic [DW-1:0] core_din;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_dout = '0;
  logic [1:0]    core_nerr = '0;
  logic [DW-1:0] data_out;
  logic [1:0]    num_of_errors;
  logic          operation_done, busy, timeout_err;

  always #5 clk = ~clk;

  enc_dec_seq #(
    .DATA_WIDTH(DW),
    .TIMEOUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ctrl_op       (ctrl_op),
    .data_in       (data_in),
    .codeword_width(codeword_width),
    .noise         (noise),
    .core_start    (core_start),
    .core_mode     (core_mode),
    .core_width    (core_width),
    .core_din      (core_din),
    .core_done     (core_done),
    .core_dout     (core_dout),
    .core_nerr     (core_nerr),
    .data_out      (data_out),
    .num_of_errors (num_of_errors),
    .operation_done(operation_done),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  typedef struct packed {
    logic [31:0] din;
    logic        mode;
    logic [1:0]  width;
  } issue_t;

  typedef struct packed {
    logic [31:0] dout;
    logic [1:0]  nerr;
    logic        to;
  } done_t;

  issue_t      exp_issue[$];
  done_t       exp_done[$];
  issue_t      ei;
  done_t       ed;
  logic [31:0] hold_dout = '0;
  logic [1:0]  hold_nerr = '0;
  logic        hold_to = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Reference: what the core must be asked for and what the command must return.
  task automatic predict(input logic [1:0] op, input logic [31:0] data, input logic [1:0] w,
                         input logic [31:0] nz, input logic [31:0] r1, input logic [1:0] n1,
                         input logic [31:0] r2, input logic [1:0] n2, input logic to);
    issue_t      i;
    done_t       d;
    logic [31:0] m;
    m = (w == 2'd0) ? 32'h0000_00FF : (w == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    i.width = w;
    i.din   = data;
    i.mode  = (op == 2'd1);
    if (op != 2'd3) exp_issue.push_back(i);
    if (op == 2'd3 || to) begin
      d.dout = '0;
      d.nerr = 2'b11;
      d.to   = to;
    end else if (op == 2'd2) begin
      i.din  = r1 ^ (nz & m);
      i.mode = 1'b1;
      exp_issue.push_back(i);
      d.dout = r2;
      d.nerr = n2;
      d.to   = 1'b0;
    end else begin
      d.dout = r1;
      d.nerr = (op == 2'd0) ? 2'b00 : n1;
      d.to   = 1'b0;
    end
    exp_done.push_back(d);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_dout = '0;
      hold_nerr = '0;
      hold_to   = 1'b0;
    end else begin
      if (core_start) begin
        if (exp_issue.size() == 0) begin
          chk("unexpected_core_start", {31'd0, core_start}, 32'd0);
        end else begin
          ei = exp_issue.pop_front();
          chk("core_din", core_din, ei.din);
          chk("core_mode", {31'd0, core_mode}, {31'd0, ei.mode});
          chk("core_width", {30'd0, core_width}, {30'd0, ei.width});
        end
      end
      if (operation_done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_operation_done", {31'd0, operation_done}, 32'd0);
        end else begin
          ed = exp_done.pop_front();
          hold_dout = ed.dout;
          hold_nerr = ed.nerr;
          hold_to   = ed.to;
          chk("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end
      chk("data_out", data_out, hold_dout);
      chk("num_of_errors", {30'd0, num_of_errors}, {30'd0, hold_nerr});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, hold_to});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] data, input logic [1:0] w,
                     input logic [31:0] nz);
    ctrl_op        = op;
    data_in        = data;
    codeword_width = w;
    noise          = nz;
    start          = 1'b1;
    tick();
    start   = 1'b0;
    hold_to = 1'b0;
  endtask

  task automatic respond(input logic [31:0] r, input logic [1:0] n, input int delay);
    repeat (delay) tick();
    core_done = 1'b1;
    core_dout = r;
    core_nerr = n;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    core_nerr = '0;
  endtask

  task automatic serve(input logic [31:0] r, input logic [1:0] n, input int delay);
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (core_start) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("core_start_seen", {31'd0, found}, 32'd1);
    if (found) respond(r, n, delay);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got %0d failures", n_fail);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_core_din", core_din, 32'd0);
    rst = 1'b0;
    tick();

    // Encode: done lands on cycle 4, encoder error count forced to zero.
    predict(2'd0, 32'h0000_00A5, 2'd0, '0, 32'h0000_0A5B, 2'd2, '0, 2'd0, 1'b0);
    cmd(2'd0, 32'h0000_00A5, 2'd0, '0);
    chk("enc_core_start_c1", {31'd0, core_start}, 32'd1);
    chk("enc_busy_c1", {31'd0, busy}, 32'd1);
    serve(32'h0000_0A5B, 2'd2, 2);
    chk("enc_done_c4", {31'd0, operation_done}, 32'd1);
    chk("enc_dout_c4", data_out, 32'h0000_0A5B);
    chk("enc_nerr_c4", {30'd0, num_of_errors}, 32'd0);
    tick();
    chk("enc_idle_c5", {31'd0, busy}, 32'd0);

    // Full channel, 8-bit mask.
    predict(2'd2, 32'h0000_005A, 2'd0, 32'h0000_0101, 32'h0000_00F0, 2'd0,
            32'h0000_005A, 2'd1, 1'b0);
    cmd(2'd2, 32'h0000_005A, 2'd0, 32'h0000_0101);
    serve(32'h0000_00F0, 2'd0, 2);
    chk("chan_noise_no_done", {31'd0, operation_done}, 32'd0);
    tick();
    chk("chan_second_start", {31'd0, core_start}, 32'd1);
    chk("chan_second_din", core_din, 32'h0000_00F1);
    chk("chan_second_mode", {31'd0, core_mode}, 32'd1);
    serve(32'h0000_005A, 2'd1, 2);
    chk("chan_done", {31'd0, operation_done}, 32'd1);
    chk("chan_nerr", {30'd0, num_of_errors}, 32'd1);
    tick();

    // Full channel, 16-bit mask, upper bits pass through.
    predict(2'd2, 32'h0000_1234, 2'd1, 32'hFFFF_0003, 32'hABCD_1200, 2'd0,
            32'h0000_1234, 2'd2, 1'b0);
    cmd(2'd2, 32'h0000_1234, 2'd1, 32'hFFFF_0003);
    serve(32'hABCD_1200, 2'd0, 1);
    tick();
    chk("chan16_second_din", core_din, 32'hABCD_1203);
    serve(32'h0000_1234, 2'd2, 3);
    tick();

    // Illegal op completes on cycle 1 without touching the core.
    predict(2'd3, 32'h0000_0077, 2'd0, '0, '0, 2'd0, '0, 2'd0, 1'b0);
    cmd(2'd3, 32'h0000_0077, 2'd0, '0);
    chk("ill_done_c1", {31'd0, operation_done}, 32'd1);
    chk("ill_no_core_start", {31'd0, core_start}, 32'd0);
    chk("ill_nerr", {30'd0, num_of_errors}, 32'd3);
    tick();
    chk("ill_idle", {31'd0, busy}, 32'd0);

    // Start during WAIT and stray core_done in IDLE are ignored.
    predict(2'd1, 32'h0000_0033, 2'd2, '0, 32'hC0DE_0033, 2'd2, '0, 2'd0, 1'b0);
    cmd(2'd1, 32'h0000_0033, 2'd2, 32'h0000_FFFF);
    tick();
    ctrl_op        = 2'd3;
    data_in        = 32'hDEAD_0000;
    codeword_width = 2'd0;
    start          = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_width_kept", {30'd0, core_width}, 32'd2);
    respond(32'hC0DE_0033, 2'd2, 0);
    chk("dec_done", {31'd0, operation_done}, 32'd1);
    chk("dec_nerr", {30'd0, num_of_errors}, 32'd2);
    tick();
    core_done = 1'b1;
    core_dout = 32'hDEAD_BEEF;
    core_nerr = 2'd1;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    core_nerr = '0;
    tick();
    chk("stray_done_ignored", data_out, 32'hC0DE_0033);

    // Start in the DONE cycle is dropped; the next IDLE cycle is accepted.
    predict(2'd0, 32'h0000_0011, 2'd0, '0, 32'h0000_0111, 2'd0, '0, 2'd0, 1'b0);
    cmd(2'd0, 32'h0000_0011, 2'd0, '0);
    serve(32'h0000_0111, 2'd0, 1);
    chk("a_done_c3", {31'd0, operation_done}, 32'd1);
    ctrl_op = 2'd1;
    data_in = 32'h0000_0099;
    start   = 1'b1;
    tick();
    chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    predict(2'd0, 32'h0000_0022, 2'd1, '0, 32'h0000_0222, 2'd0, '0, 2'd0, 1'b0);
    cmd(2'd0, 32'h0000_0022, 2'd1, '0);
    chk("b_accepted", {31'd0, core_start}, 32'd1);
    chk("b_din", core_din, 32'h0000_0022);
    serve(32'h0000_0222, 2'd0, 1);
    tick();

    // Asynchronous reset in WAIT aborts without completion.
    predict(2'd0, 32'h0000_0044, 2'd1, '0, 32'h0000_0444, 2'd0, '0, 2'd0, 1'b0);
    cmd(2'd0, 32'h0000_0044, 2'd1, '0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_data_out", data_out, 32'd0);
    chk("arst_core_din", core_din, 32'd0);
    chk("arst_core_width", {30'd0, core_width}, 32'd0);
    chk("arst_op_done", {31'd0, operation_done}, 32'd0);
    exp_issue.delete();
    exp_done.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_no_done", {31'd0, operation_done}, 32'd0);
    predict(2'd0, 32'h0000_0055, 2'd0, '0, 32'h0000_0555, 2'd0, '0, 2'd0, 1'b0);
    cmd(2'd0, 32'h0000_0055, 2'd0, '0);
    serve(32'h0000_0555, 2'd0, 2);
    chk("post_rst_done", data_out, 32'h0000_0555);
    tick();

`ifdef ENC_DEC_SEQ_TIMEOUT_EN
    // Core silent: four WAIT cycles then timeout on cycle 6.
    predict(2'd0, 32'h0000_0066, 2'd0, '0, '0, 2'd0, '0, 2'd0, 1'b1);
    cmd(2'd0, 32'h0000_0066, 2'd0, '0);
    repeat (5) tick();
    chk("wd_done_c6", {31'd0, operation_done}, 32'd1);
    chk("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("wd_nerr", {30'd0, num_of_errors}, 32'd3);
    tick();
    chk("wd_err_held", {31'd0, timeout_err}, 32'd1);
    // core_done on the limit cycle wins.
    predict(2'd0, 32'h0000_0077, 2'd0, '0, 32'h0000_7777, 2'd0, '0, 2'd0, 1'b0);
    cmd(2'd0, 32'h0000_0077, 2'd0, '0);
    serve(32'h0000_7777, 2'd0, 4);
    chk("wd_limit_done", {31'd0, operation_done}, 32'd1);
    chk("wd_limit_no_err", {31'd0, timeout_err}, 32'd0);
    chk("wd_limit_dout", data_out, 32'h0000_7777);
    tick();
`else
    // Without the watchdog a slow core is simply waited for.
    predict(2'd0, 32'h0000_0088, 2'd0, '0, 32'h0000_8888, 2'd0, '0, 2'd0, 1'b0);
    cmd(2'd0, 32'h0000_0088, 2'd0, '0);
    serve(32'h0000_8888, 2'd0, 12);
    chk("slow_core_done", {31'd0, operation_done}, 32'd1);
    chk("slow_core_dout", data_out, 32'h0000_8888);
    chk("slow_core_no_err", {31'd0, timeout_err}, 32'd0);
    tick();
`endif

    tick();
    chk("issue_queue_drained", exp_issue.size(), 32'd0);
    chk("done_queue_drained", exp_done.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
